mesi_isc_snoop_seq: RTL and testbench

//  Sequences one coherence broadcast at a time on the four coherence buses.

---
 rtl/mesi_isc_snoop_seq_pkg.sv | 11 +
 rtl/mesi_isc_snoop_seq_if.sv | 30 +++
 rtl/mesi_isc_snoop_seq_ack_timer.sv | 19 +
 rtl/mesi_isc_snoop_seq.sv | 80 ++++++++
 tb/tb_mesi_isc_snoop_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mesi_isc_snoop_seq_pkg.sv
// mesi_isc_snoop_seq_pkg: coherence bus command codes, sequencer states and width constants
package mesi_isc_snoop_seq_pkg;
  localparam int CMD_W = 3;
  localparam int TIMER_W = 16;
  localparam logic [CMD_W-1:0] CMD_NOP = 3'd0;
  localparam logic [CMD_W-1:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [CMD_W-1:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [CMD_W-1:0] CMD_EN_WR = 3'd3;
  localparam logic [CMD_W-1:0] CMD_EN_RD = 3'd4;
  typedef enum logic [1:0] {IDLE, SNOOP, EN} state_t;
endpackage

// File: rtl/mesi_isc_snoop_seq_if.sv
// mesi_isc_snoop_seq_if: broadcast request handshake plus the four coherence buses
// slave: sequencer side (takes req_*, cbus_ack*, drives ready/cbus_addr/cbus_cmd*/done/timeout)
// master: requester and CPU side
interface mesi_isc_snoop_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CBUS_CMD_WIDTH = 3
);
  logic req_valid_i;
  logic req_ready_o;
  logic req_wr_i;
  logic [1:0] req_id_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [ADDR_WIDTH-1:0] cbus_addr_o;
  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd3_o, cbus_cmd2_o, cbus_cmd1_o, cbus_cmd0_o;
  logic cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i;
  logic done_o;
  logic timeout_o;
  modport slave (
    input req_valid_i, req_wr_i, req_id_i, req_addr_i,
    input cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i,
    output req_ready_o, cbus_addr_o, done_o, timeout_o,
    output cbus_cmd3_o, cbus_cmd2_o, cbus_cmd1_o, cbus_cmd0_o
  );
  modport master (
    output req_valid_i, req_wr_i, req_id_i, req_addr_i,
    output cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i,
    input req_ready_o, cbus_addr_o, done_o, timeout_o,
    input cbus_cmd3_o, cbus_cmd2_o, cbus_cmd1_o, cbus_cmd0_o
  );
endinterface

// File: rtl/mesi_isc_snoop_seq_ack_timer.sv
// mesi_isc_snoop_seq_ack_timer: saturating ack-progress counter, expires at LIMIT (0 = never)
// ports: clk, rst, i_clr (restart at 0), i_en (count), o_expire (count == LIMIT)
module mesi_isc_snoop_seq_ack_timer
  import mesi_isc_snoop_seq_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  logic [TIMER_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_expire = (LIMIT != 0) && (r_cnt == TIMER_W'(LIMIT));
endmodule

// File: rtl/mesi_isc_snoop_seq.sv
// mesi_isc_snoop_seq: sequences one coherence broadcast (snoop others, collect acks, enable originator)
// ports: clk, rst (sync, active high), bus (slave modport: request handshake, cbus addr/cmd/ack, done/timeout)
module mesi_isc_snoop_seq
  import mesi_isc_snoop_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  mesi_isc_snoop_seq_if.slave bus
);
  state_t r_state, w_state_n;
  logic [3:0] r_pend, w_pend_n, w_ack, w_act, w_cnt_ack;
  logic [3:0][CBUS_CMD_WIDTH-1:0] r_cmd, w_cmd_n;
  logic [1:0] r_id, w_id;
  logic r_wr, w_wr, r_ready, r_done, r_to, w_done, w_to, w_accept, w_expire;
  logic [ADDR_WIDTH-1:0] r_addr;
  assign w_ack = {bus.cbus_ack3_i, bus.cbus_ack2_i, bus.cbus_ack1_i, bus.cbus_ack0_i};
  // an ack only counts on a port currently driving a command
  always_comb
    for (int i = 0; i < 4; i++) w_act[i] = r_cmd[i] != CBUS_CMD_WIDTH'(CMD_NOP);
  assign w_cnt_ack = w_ack & w_act;
  assign w_accept = r_state == IDLE && bus.req_valid_i;
  assign w_id = w_accept ? bus.req_id_i : r_id;
  assign w_wr = w_accept ? bus.req_wr_i : r_wr;
  assign w_to = r_state != IDLE && w_expire && ~|w_cnt_ack;
  assign w_done = r_state == EN && |w_cnt_ack;
  mesi_isc_snoop_seq_ack_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_clr(r_state == IDLE || |w_cnt_ack),
    .i_en(1'b1),
    .o_expire(w_expire)
  );
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_n;
  always_comb begin
    w_pend_n = w_to ? 4'b0 : w_accept ? ~(4'b1 << bus.req_id_i) : r_state == SNOOP ? r_pend & ~w_cnt_ack : 4'b0;
    w_state_n = r_state == IDLE ? (w_accept ? SNOOP : IDLE)
              : w_to ? IDLE
              : r_state == SNOOP ? (w_pend_n == 4'b0 ? EN : SNOOP)
              : (w_done ? IDLE : EN);
  end
  // commands are a pure function of the next state, so every port output is registered
  always_comb begin
    w_cmd_n = '0;
    for (int i = 0; i < 4; i++)
      w_cmd_n[i] = (w_state_n == SNOOP && w_pend_n[i]) ? CBUS_CMD_WIDTH'(w_wr ? CMD_WR_SNOOP : CMD_RD_SNOOP)
                 : (w_state_n == EN && w_id == 2'(i)) ? CBUS_CMD_WIDTH'(w_wr ? CMD_EN_WR : CMD_EN_RD)
                 : CBUS_CMD_WIDTH'(CMD_NOP);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_pend <= '0;
      r_cmd <= '0;
      r_id <= '0;
      r_wr <= 1'b0;
      r_addr <= '0;
      r_ready <= 1'b1;
      r_done <= 1'b0;
      r_to <= 1'b0;
    end else begin
      r_pend <= w_pend_n;
      r_cmd <= w_cmd_n;
      r_id <= w_id;
      r_wr <= w_wr;
      if (w_accept) r_addr <= bus.req_addr_i;
      r_ready <= w_state_n == IDLE;
      r_done <= w_done;
      r_to <= w_to;
    end
  assign bus.req_ready_o = r_ready;
  assign bus.cbus_addr_o = r_addr;
  assign {bus.cbus_cmd3_o, bus.cbus_cmd2_o, bus.cbus_cmd1_o, bus.cbus_cmd0_o} = r_cmd;
  assign bus.done_o = r_done;
  assign bus.timeout_o = r_to;
endmodule

// File: tb/tb_mesi_isc_snoop_seq.sv
// tb_mesi_isc_snoop_seq: directed-vector bench for the snoop sequencer
module tb_mesi_isc_snoop_seq;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  logic [11:0] cmd;
  mesi_isc_snoop_seq_if #(.ADDR_WIDTH(32), .CBUS_CMD_WIDTH(3)) bus ();
  mesi_isc_snoop_seq #(.ADDR_WIDTH(32), .CBUS_CMD_WIDTH(3), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign cmd = {bus.cbus_cmd3_o, bus.cbus_cmd2_o, bus.cbus_cmd1_o, bus.cbus_cmd0_o};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic acks(input logic [3:0] a);
    {bus.cbus_ack3_i, bus.cbus_ack2_i, bus.cbus_ack1_i, bus.cbus_ack0_i} = a;
  endtask
  task automatic req(input logic wr, input logic [1:0] id, input logic [31:0] addr);
    bus.req_valid_i = 1'b1;
    bus.req_wr_i = wr;
    bus.req_id_i = id;
    bus.req_addr_i = addr;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_wr_i = 1'b0;
    bus.req_id_i = 2'd0;
    bus.req_addr_i = '0;
    acks(4'b0);
    repeat (2) cyc();
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_addr", bus.cbus_addr_o, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    rst = 1'b0;
    cyc();
    // 1: write from cpu0, all snoop acks together
    req(1'b1, 2'd0, 32'h1);
    cyc();
    bus.req_valid_i = 1'b0;
    chk("s1_ready", bus.req_ready_o, 0);
    chk("s1_snoop", cmd, {3'd1, 3'd1, 3'd1, 3'd0});
    chk("s1_addr", bus.cbus_addr_o, 32'h1);
    acks(4'b1110);
    cyc();
    chk("s1_en", cmd, {3'd0, 3'd0, 3'd0, 3'd3});
    chk("s1_done_early", bus.done_o, 0);
    acks(4'b0001);
    cyc();
    chk("s1_done", bus.done_o, 1);
    chk("s1_ready_done", bus.req_ready_o, 1);
    chk("s1_cmd_idle", cmd, 0);
    acks(4'b0);
    cyc();
    chk("s1_done_pulse", bus.done_o, 0);
    // 2: read from cpu2, staggered acks
    req(1'b0, 2'd2, 32'hABCD0000);
    cyc();
    bus.req_valid_i = 1'b0;
    chk("s2_snoop", cmd, {3'd2, 3'd0, 3'd2, 3'd2});
    chk("s2_addr", bus.cbus_addr_o, 32'hABCD0000);
    cyc();
    acks(4'b1000);
    cyc();
    chk("s2_ack3", cmd, {3'd0, 3'd0, 3'd2, 3'd2});
    acks(4'b0);
    cyc();
    acks(4'b0001);
    cyc();
    chk("s2_ack0", cmd, {3'd0, 3'd0, 3'd2, 3'd0});
    acks(4'b0010);
    cyc();
    chk("s2_en", cmd, {3'd0, 3'd4, 3'd0, 3'd0});
    chk("s2_no_done", bus.done_o, 0);
    acks(4'b0100);
    cyc();
    chk("s2_done", bus.done_o, 1);
    chk("s2_cmd_idle", cmd, 0);
    acks(4'b0);
    cyc();
    // 3: acks on NOP ports are ignored
    req(1'b1, 2'd0, 32'h300);
    cyc();
    bus.req_valid_i = 1'b0;
    acks(4'b0001);
    cyc();
    chk("s3_orig_ack", cmd, {3'd1, 3'd1, 3'd1, 3'd0});
    chk("s3_ready", bus.req_ready_o, 0);
    acks(4'b0010);
    cyc();
    chk("s3_ack1", cmd, {3'd1, 3'd1, 3'd0, 3'd0});
    acks(4'b0011);
    cyc();
    chk("s3_nop_acks", cmd, {3'd1, 3'd1, 3'd0, 3'd0});
    acks(4'b1100);
    cyc();
    chk("s3_en", cmd, {3'd0, 3'd0, 3'd0, 3'd3});
    acks(4'b0001);
    cyc();
    chk("s3_done", bus.done_o, 1);
    acks(4'b0);
    cyc();
    // 4: port1 never acks, timeout after 4 idle cycles
    req(1'b1, 2'd3, 32'h40);
    cyc();
    bus.req_valid_i = 1'b0;
    chk("s4_snoop", cmd, {3'd0, 3'd1, 3'd1, 3'd1});
    acks(4'b0101);
    cyc();
    acks(4'b0);
    repeat (4) cyc();
    chk("s4_pre_timeout", bus.timeout_o, 0);
    chk("s4_pre_cmd", cmd, {3'd0, 3'd0, 3'd1, 3'd0});
    cyc();
    chk("s4_timeout", bus.timeout_o, 1);
    chk("s4_cmd", cmd, 0);
    chk("s4_ready", bus.req_ready_o, 1);
    chk("s4_no_done", bus.done_o, 0);
    cyc();
    chk("s4_timeout_pulse", bus.timeout_o, 0);
    // 5: reset while in EN
    req(1'b0, 2'd1, 32'h77);
    cyc();
    bus.req_valid_i = 1'b0;
    acks(4'b1101);
    cyc();
    chk("s5_en", cmd, {3'd0, 3'd0, 3'd4, 3'd0});
    rst = 1'b1;
    acks(4'b0);
    cyc();
    chk("s5_cmd", cmd, 0);
    chk("s5_ready", bus.req_ready_o, 1);
    chk("s5_addr", bus.cbus_addr_o, 0);
    chk("s5_done", bus.done_o, 0);
    rst = 1'b0;
    cyc();
    chk("s5_done_after", bus.done_o, 0);
    // 6: back-to-back requests
    req(1'b1, 2'd0, 32'h5);
    cyc();
    acks(4'b1110);
    cyc();
    acks(4'b0001);
    req(1'b0, 2'd1, 32'h6);
    cyc();
    chk("s6_done", bus.done_o, 1);
    chk("s6_ready", bus.req_ready_o, 1);
    acks(4'b0);
    cyc();
    bus.req_valid_i = 1'b0;
    chk("s6_addr", bus.cbus_addr_o, 32'h6);
    chk("s6_snoop", cmd, {3'd2, 3'd2, 3'd0, 3'd2});
    chk("s6_busy", bus.req_ready_o, 0);
    acks(4'b1101);
    cyc();
    chk("s6_en", cmd, {3'd0, 3'd0, 3'd4, 3'd0});
    acks(4'b0010);
    cyc();
    chk("s6_done2", bus.done_o, 1);
    acks(4'b0);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
